// File: rtl/crossbar_pkg.sv
// crossbar_pkg: types shared by the crossbar family (allocator, datapath).
package crossbar_pkg;

    // Per-output lock state.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } xbar_state_e;

    localparam int PORTS_MIN = 2;
    localparam int PORTS_MAX = 16;

endpackage

// File: rtl/crossbar_alloc_if.sv
// crossbar_alloc_if: request/transfer inputs and grant outputs of the allocator.
interface crossbar_alloc_if #(
    parameter int PORTS = 4,
    parameter int DW    = $clog2(PORTS)
);
    logic [PORTS-1:0] req_i;
    logic [DW-1:0]    dest_i [PORTS];
    logic [PORTS-1:0] xfer_i;
    logic [PORTS-1:0] tail_i;
    logic [DW-1:0]    dest_o [PORTS];
    logic [PORTS-1:0] dest_en_o;
    logic [PORTS-1:0] busy_o;

    modport master (
        output req_i, dest_i, xfer_i, tail_i,
        input  dest_o, dest_en_o, busy_o
    );

    modport slave (
        input  req_i, dest_i, xfer_i, tail_i,
        output dest_o, dest_en_o, busy_o
    );
endinterface

// File: rtl/crossbar_alloc_arb.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i.
module rr_arbiter #(
    parameter int PORTS = 4,
    parameter int DW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [DW-1:0]    ptr_i,
    output logic [PORTS-1:0] gnt_o,
    output logic             valid_o
);
    localparam int unsigned N = PORTS;

    int unsigned   idx;
    logic [DW-1:0] sel;

    // Scan from the pointer upward, wrapping past PORTS-1, and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = DW'(idx);
            if (!valid_o && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/crossbar_alloc.sv
// crossbar_alloc: per-output IDLE/LOCKED allocator with round-robin selection.
module crossbar_alloc
    import crossbar_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int DW    = $clog2(PORTS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    crossbar_alloc_if.slave  bus
);
    localparam int unsigned N = PORTS;

    xbar_state_e      state_q [PORTS];
    xbar_state_e      state_d [PORTS];
    logic [DW-1:0]    owner_q [PORTS];
    logic [DW-1:0]    owner_d [PORTS];
    logic [DW-1:0]    ptr_q   [PORTS];
    logic [DW-1:0]    ptr_d   [PORTS];
    logic             armed_q;
    logic [PORTS-1:0] owns;
    logic [DW-1:0]    dest_dec [PORTS];
    logic [PORTS-1:0] cand     [PORTS];
    logic [PORTS-1:0] gnt      [PORTS];
    logic             gnt_vld  [PORTS];
    logic [DW-1:0]    own;

    function automatic logic [DW-1:0] onehot_idx(input logic [PORTS-1:0] oh);
        logic [DW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = DW'(i);
            end
        end
        return idx;
    endfunction

    // Decode which inputs hold a lock, and onto which output, from registered state.
    always_comb begin
        owns = '0;
        for (int unsigned i = 0; i < N; i++) begin
            dest_dec[i] = '0;
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (state_q[j] == LOCKED) begin
                owns[owner_q[j]]     = 1'b1;
                dest_dec[owner_q[j]] = DW'(j);
            end
        end
    end

    // Drive the interface outputs purely from the registered decode.
    always_comb begin
        bus.dest_en_o = owns;
        bus.busy_o    = '0;
        for (int unsigned j = 0; j < N; j++) begin
            bus.busy_o[j] = (state_q[j] == LOCKED);
            bus.dest_o[j] = dest_dec[j];
        end
    end

    // Candidate inputs per output: requesting it and not already owning another output.
    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            cand[j] = '0;
            for (int unsigned i = 0; i < N; i++) begin
                cand[j][i] = bus.req_i[i] && (bus.dest_i[i] == DW'(j)) && !owns[i];
            end
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_arb
        rr_arbiter #(
            .PORTS (PORTS),
            .DW    (DW)
        ) u_arb (
            .req_i   (cand[j]),
            .ptr_i   (ptr_q[j]),
            .gnt_o   (gnt[j]),
            .valid_o (gnt_vld[j])
        );
    end

    // Next state per output: lock on a grant, release on tail transfer or abort.
    always_comb begin
        own = '0;
        for (int unsigned j = 0; j < N; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            own        = owner_q[j];
            case (state_q[j])
                IDLE: begin
                    if (armed_q && gnt_vld[j]) begin
                        state_d[j] = LOCKED;
                        owner_d[j] = onehot_idx(gnt[j]);
                    end
                end
                LOCKED: begin
                    if ((bus.xfer_i[own] && bus.tail_i[own]) || !bus.req_i[own]) begin
                        state_d[j] = IDLE;
                        ptr_d[j]   = (own == DW'(N - 1)) ? '0 : own + 1'b1;
                    end
                end
                default: state_d[j] = IDLE;
            endcase
        end
    end

    // State registers; armed_q holds off arbitration until the second edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q <= 1'b0;
            for (int unsigned j = 0; j < N; j++) begin
                state_q[j] <= IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            armed_q <= 1'b1;
            for (int unsigned j = 0; j < N; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end
endmodule

// File: tb/tb_crossbar_alloc.sv
// tb_crossbar_alloc: table vectors, hand sequences and randomized model comparison.
module tb_crossbar_alloc;
    logic clk;
    logic rst_n;

    crossbar_alloc_if #(.PORTS(4)) bus ();

    crossbar_alloc #(.PORTS(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: owner per output (-1 = free), pointer per output, armed flag.
    int m_own [4];
    int m_ptr [4];
    bit m_armed;

    typedef struct {
        logic [3:0] req;
        logic [7:0] dest;
        logic [3:0] xfer;
        logic [3:0] tail;
        logic [3:0] en;
        logic [3:0] busy;
        logic [7:0] dsto;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_own[j] = -1;
            m_ptr[j] = 0;
        end
        m_armed = 1'b0;
    endtask

    task automatic model_edge();
        int nown [4];
        int nptr [4];
        bit busy_in [4];
        int k;
        int c;
        if (!rst_n) return;
        for (int i = 0; i < 4; i++) busy_in[i] = 1'b0;
        for (int j = 0; j < 4; j++) if (m_own[j] >= 0) busy_in[m_own[j]] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            nown[j] = m_own[j];
            nptr[j] = m_ptr[j];
            if (m_own[j] >= 0) begin
                k = m_own[j];
                if ((bus.xfer_i[k] && bus.tail_i[k]) || !bus.req_i[k]) begin
                    nown[j] = -1;
                    nptr[j] = (k + 1) % 4;
                end
            end else if (m_armed) begin
                for (int s = 0; s < 4; s++) begin
                    c = (m_ptr[j] + s) % 4;
                    if (bus.req_i[c] && int'(bus.dest_i[c]) == j && !busy_in[c]) begin
                        nown[j] = c;
                        break;
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            m_own[j] = nown[j];
            m_ptr[j] = nptr[j];
        end
        m_armed = 1'b1;
    endtask

    function automatic logic [3:0] m_en();
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) if (m_own[j] >= 0) r[m_own[j]] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r[j] = (m_own[j] >= 0);
        return r;
    endfunction

    function automatic logic [7:0] m_dsto();
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) if (m_own[j] >= 0) r[2*m_own[j] +: 2] = 2'(j);
        return r;
    endfunction

    function automatic logic [7:0] dut_dsto();
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = bus.dest_o[i];
        return r;
    endfunction

    task automatic set_in(input logic [3:0] r, input logic [7:0] d,
                          input logic [3:0] x, input logic [3:0] t);
        bus.req_i  = r;
        bus.xfer_i = x;
        bus.tail_i = t;
        for (int i = 0; i < 4; i++) bus.dest_i[i] = d[2*i +: 2];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] en,
                              input logic [3:0] busy, input logic [7:0] dsto);
        check({tag, "_en"},   bus.dest_en_o, en);
        check({tag, "_busy"}, bus.busy_o,    busy);
        check({tag, "_dest"}, dut_dsto(),    dsto);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n = 1'b0;
        set_in(4'b0000, 8'h00, 4'b0000, 4'b0000);

        // Contention on output 3, then rotation wrap, single-flit and abort.
        tbl[0]  = '{4'b0111, 8'hFF, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 8'h03};
        tbl[1]  = '{4'b0111, 8'hFF, 4'b0101, 4'b0100, 4'b0001, 4'b1000, 8'h03};
        tbl[2]  = '{4'b0111, 8'hFF, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'h00};
        tbl[3]  = '{4'b0110, 8'hFF, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 8'h0C};
        tbl[4]  = '{4'b0110, 8'hFF, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 8'h0C};
        tbl[5]  = '{4'b0110, 8'hFF, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 8'h00};
        tbl[6]  = '{4'b0100, 8'hFF, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 8'h30};
        tbl[7]  = '{4'b0100, 8'hFF, 4'b0100, 4'b0000, 4'b0100, 4'b1000, 8'h30};
        tbl[8]  = '{4'b0100, 8'hFF, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 8'h00};
        tbl[9]  = '{4'b0101, 8'hFF, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 8'h03};
        tbl[10] = '{4'b0101, 8'hFF, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'h00};
        tbl[11] = '{4'b0100, 8'hFF, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 8'h30};
        tbl[12] = '{4'b0000, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00};

        #12;
        check_outs("reset", 4'b0000, 4'b0000, 8'h00);
        rst_n = 1'b1;
        step();
        check_outs("arm", 4'b0000, 4'b0000, 8'h00);

        for (int r = 0; r < 13; r++) begin
            set_in(tbl[r].req, tbl[r].dest, tbl[r].xfer, tbl[r].tail);
            step();
            check_outs($sformatf("tbl%0d", r), tbl[r].en, tbl[r].busy, tbl[r].dsto);
        end

        // Parallel grants 0->1, 1->2, 2->3, 3->0 in one cycle.
        set_in(4'b1111, 8'h39, 4'b0000, 4'b0000);
        step();
        check_outs("par", 4'b1111, 4'b1111, 8'h39);
        // Owner 0 retargets while locked: lock must hold.
        set_in(4'b1111, 8'h3A, 4'b0000, 4'b0000);
        step();
        check_outs("stable", 4'b1111, 4'b1111, 8'h39);
        set_in(4'b0000, 8'h00, 4'b0000, 4'b0000);
        step();
        check_outs("par_rel", 4'b0000, 4'b0000, 8'h00);

        // Abort: input 1 on output 0 drops req without tail; pointer then favours input 2.
        set_in(4'b0010, 8'h00, 4'b0000, 4'b0000);
        step();
        check_outs("abort_lock", 4'b0010, 4'b0001, 8'h00);
        set_in(4'b0010, 8'h00, 4'b0010, 4'b0000);
        step();
        check_outs("abort_hold", 4'b0010, 4'b0001, 8'h00);
        set_in(4'b0000, 8'h00, 4'b0000, 4'b0000);
        step();
        check_outs("abort_rel", 4'b0000, 4'b0000, 8'h00);
        set_in(4'b0110, 8'h00, 4'b0000, 4'b0000);
        step();
        check_outs("abort_ptr", 4'b0100, 4'b0001, 8'h00);
        set_in(4'b0000, 8'h00, 4'b0000, 4'b0000);
        step();

        // Mid-packet asynchronous reset with two locks, then delayed re-grant.
        set_in(4'b0011, 8'h09, 4'b0000, 4'b0000);
        step();
        check_outs("rst_pre", 4'b0011, 4'b0110, 8'h09);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("rst_async", 4'b0000, 4'b0000, 8'h00);
        #2;
        rst_n = 1'b1;
        step();
        check_outs("rst_edge1", 4'b0000, 4'b0000, 8'h00);
        step();
        check_outs("rst_edge2", 4'b0011, 4'b0110, 8'h09);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_i[i]) begin
                    bus.req_i[i] = ($urandom_range(0, 99) < 85);
                end else begin
                    bus.req_i[i]  = ($urandom_range(0, 1) == 1);
                    bus.dest_i[i] = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 9) == 0) bus.dest_i[i] = 2'($urandom_range(0, 3));
                bus.xfer_i[i] = 1'($urandom_range(0, 1));
                bus.tail_i[i] = ($urandom_range(0, 3) == 0);
            end
            step();
            check_outs($sformatf("rand%0d", c), m_en(), m_busy(), m_dsto());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
